decimator: RTL and testbench

- Polyphase FIR decimator; the downsampling counterpart of the team's interpolator.
- Accepts one input sample per i_ce strobe and emits one filtered output for every DOWNFACTOR accepted inputs.
- A single time-shared multiplier-accumulator walks all NTAPS coefficients after each decimation boundary.
- Sits on the receive or downconversion path, ahead of rate-reduced DSP.

---
 rtl/decimator.sv | 86 ++++++++
 tb/tb_decimator.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/decimator.sv
// decimator: polyphase FIR decimator with one shared MAC, h[k] = TAPS[k*TW +: TW]; define DECIMATOR_SAT_EN to saturate o_result
module decimator #(
  parameter int DOWNFACTOR = 4,
  parameter int NTAPS = 32,
  parameter int IW = 16,
  parameter int TW = 16,
  parameter int OW = 32,
  parameter logic [NTAPS*TW-1:0] TAPS = {NTAPS{{{(TW-1){1'b0}}, 1'b1}}}
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ce,
  input  logic [IW-1:0] i_sample,
  output logic          o_ready,
  output logic [OW-1:0] o_result,
  output logic          o_valid,
  output logic          o_overrun
);
  localparam int AW = IW + TW + $clog2(NTAPS);
  localparam int KW = $clog2(NTAPS);
  localparam int PW = $clog2(DOWNFACTOR);
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t state, state_n;
  logic [PW-1:0] phase;
  logic [KW-1:0] k;
  logic signed [AW-1:0] acc;
  logic signed [IW-1:0] d [NTAPS];
  logic signed [TW-1:0] hk;
  logic signed [IW+TW-1:0] prod;
  logic signed [OW-1:0] red;
  logic accept, wrap;
  assign o_ready = state == IDLE;
  assign accept = i_ce & o_ready;
  assign wrap = accept && phase == PW'(DOWNFACTOR - 1);
  assign hk = TAPS[int'(k)*TW +: TW];
  assign prod = d[k] * hk;
`ifdef DECIMATOR_SAT_EN
  if (AW > OW) begin : g_sat
    localparam logic signed [AW-1:0] MAXV = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};
    assign red = acc > MAXV ? OW'(MAXV) : acc < MINV ? OW'(MINV) : OW'(acc);
  end else begin : g_wrap
    assign red = OW'(acc);
  end
`else
  assign red = OW'(acc);
`endif
  always_ff @(posedge i_clk)
    state <= i_reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (wrap) state_n = MAC;
      MAC: if (k == KW'(NTAPS - 1)) state_n = OUT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      phase <= '0;
      k <= '0;
      acc <= '0;
      o_result <= '0;
      o_valid <= 1'b0;
      o_overrun <= 1'b0;
      for (int j = 0; j < NTAPS; j++) d[j] <= '0;
    end else begin
      o_valid <= state == OUT;
      if (state == OUT) o_result <= red;
      if (i_ce && !o_ready) o_overrun <= 1'b1;
      if (accept) begin
        d[0] <= $signed(i_sample);
        for (int j = 1; j < NTAPS; j++) d[j] <= d[j-1];
        phase <= wrap ? '0 : phase + PW'(1);
      end
      if (wrap) begin
        acc <= '0;
        k <= '0;
      end
      if (state == MAC) begin
        acc <= acc + AW'(prod);
        k <= k + KW'(1);
      end
    end
  end
endmodule

// File: tb/tb_decimator.sv
// tb_decimator: vector tables, corner sequences and a random run against a history-based FIR model
module tb_decimator;
  localparam int M = 4;
  localparam int N = 8;
  localparam logic [127:0] H1 = {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [127:0] HS = {8{16'h7FFF}};
  typedef struct { int x0; int xr; int e[4]; } vec_t;
  typedef struct { int x; int e; } svec_t;
  logic clk = 0;
  logic rst = 1, ce = 0;
  logic [15:0] x = 0;
  logic [31:0] o_result;
  logic o_ready, o_valid, o_overrun;
  logic s_rst = 1, s_ce = 0;
  logic [15:0] s_x = 0;
  logic [15:0] s_result;
  logic s_ready, s_valid, s_ov;
  int checks = 0, errors = 0, cyc = 0;
  longint vals[$], svals[$];
  int vcyc[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  decimator #(.DOWNFACTOR(M), .NTAPS(N), .IW(16), .TW(16), .OW(32), .TAPS(H1)) u_dut (
    .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_sample(x),
    .o_ready(o_ready), .o_result(o_result), .o_valid(o_valid), .o_overrun(o_overrun));
  decimator #(.DOWNFACTOR(M), .NTAPS(N), .IW(16), .TW(16), .OW(16), .TAPS(HS)) u_sat (
    .i_clk(clk), .i_reset(s_rst), .i_ce(s_ce), .i_sample(s_x),
    .o_ready(s_ready), .o_result(s_result), .o_valid(s_valid), .o_overrun(s_ov));
  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  // reference model: accepted-sample history and y[m] = sum h[k]*x[mM-1-k], wrapped to 32 bits
  int hist[$];
  int cd = 0, busy = 0;
  logic ev = 0, eo = 0;
  longint er = 0, pend = 0;
  bit rdy;
  function automatic longint yref(int m);
    longint s = 0;
    logic [63:0] t;
    for (int kk = 0; kk < N; kk++) begin
      int i = m*M - 1 - kk;
      if (i >= 0) s += longint'(kk + 1) * hist[i];
    end
    t = s;
    return longint'($signed(t[31:0]));
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      hist.delete();
      cd = 0; busy = 0; ev = 0; er = 0; eo = 0;
    end else begin
      rdy = busy == 0;
      ev = 0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin ev = 1; er = pend; end
      end
      if (busy > 0) busy--;
      if (ce && rdy) begin
        hist.push_back(int'($signed(x)));
        if (hist.size() % M == 0) begin
          pend = yref(hist.size() / M);
          cd = N + 1;
          busy = N + 1;
        end
      end else if (ce) eo = 1;
    end
    #1;
    chk("m_valid", o_valid, ev);
    chk("m_ready", o_ready, busy == 0);
    chk("m_overrun", o_overrun, eo);
    chk("m_result", $signed(o_result), er);
  end
  task automatic cyc1(input logic r, input logic c, input logic [15:0] v);
    rst = r; ce = c; x = v;
    @(posedge clk); #1;
    if (o_valid === 1'b1) begin
      vals.push_back(longint'($signed(o_result)));
      vcyc.push_back(cyc);
    end
  endtask
  task automatic s_cyc(input logic r, input logic c, input logic [15:0] v);
    s_rst = r; s_ce = c; s_x = v;
    @(posedge clk); #1;
    if (s_valid === 1'b1) svals.push_back(longint'($signed(s_result)));
  endtask
  task automatic clr();
    vals.delete();
    vcyc.delete();
  endtask
  initial begin
    vec_t tv[3];
    svec_t sv[2];
    int acc_c[16];
    tv[0] = '{1, 0, '{4, 8, 0, 0}};
    tv[1] = '{100, 100, '{1000, 3600, 3600, 3600}};
    tv[2] = '{-7, -7, '{-70, -252, -252, -252}};
`ifdef DECIMATOR_SAT_EN
    sv[0] = '{32767, 32767};
    sv[1] = '{-32767, -32768};
`else
    sv[0] = '{32767, 8};
    sv[1] = '{-32767, -8};
`endif
    cyc1(1, 0, 0);
    cyc1(1, 0, 0);
    chk("rst_ready", o_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_result", $signed(o_result), 0);
    chk("rst_overrun", o_overrun, 0);
    for (int t = 0; t < 3; t++) begin
      cyc1(1, 0, 0);
      clr();
      for (int i = 0; i < 16; i++) begin
        cyc1(0, 1, 16'(i == 0 ? tv[t].x0 : tv[t].xr));
        acc_c[i] = cyc;
        repeat (19) cyc1(0, 0, 0);
      end
      chk($sformatf("vec%0d_count", t), vals.size(), 4);
      for (int j = 0; j < vals.size() && j < 4; j++) begin
        chk($sformatf("vec%0d_y%0d", t, j), vals[j], tv[t].e[j]);
        chk($sformatf("vec%0d_lat%0d", t, j), vcyc[j] - acc_c[4*j+3], N + 1);
      end
    end
    cyc1(1, 0, 0);
    clr();
    for (int i = 1; i <= 4; i++) cyc1(0, 1, 16'(i));
    cyc1(0, 1, 16'd99);
    chk("ovr_flag", o_overrun, 1);
    repeat (12) cyc1(0, 0, 0);
    for (int i = 5; i <= 8; i++) cyc1(0, 1, 16'(i));
    repeat (12) cyc1(0, 0, 0);
    chk("ovr_count", vals.size(), 2);
    if (vals.size() == 2) begin
      chk("ovr_y1", vals[0], 20);
      chk("ovr_y2", vals[1], 120);
    end
    chk("ovr_sticky", o_overrun, 1);
    cyc1(1, 0, 0);
    clr();
    for (int i = 1; i <= 4; i++) cyc1(0, 1, 16'(i));
    cyc1(0, 0, 0);
    cyc1(0, 0, 0);
    cyc1(1, 1, 16'd77);
    chk("abort_valid", o_valid, 0);
    chk("abort_result", $signed(o_result), 0);
    chk("abort_ready", o_ready, 1);
    cyc1(0, 1, 16'd10);
    for (int i = 0; i < 3; i++) cyc1(0, 1, 16'd0);
    repeat (12) cyc1(0, 0, 0);
    chk("abort_count", vals.size(), 1);
    if (vals.size() == 1) chk("abort_y1", vals[0], 40);
    cyc1(1, 0, 0);
    clr();
    for (int i = 0; i < 200; i++) cyc1(0, o_ready, 16'($urandom));
    chk("b2b_overrun", o_overrun, 0);
    chk("b2b_enough", vals.size() >= 10, 1);
    for (int j = 1; j < vcyc.size(); j++) chk($sformatf("b2b_gap%0d", j), vcyc[j] - vcyc[j-1], N + 1 + M);
    cyc1(1, 0, 0);
    for (int i = 0; i < 800; i++) cyc1($urandom_range(0, 299) == 0, $urandom_range(0, 2) != 0, 16'($urandom));
    cyc1(0, 0, 0);
    for (int t = 0; t < 2; t++) begin
      s_cyc(1, 0, 0);
      s_cyc(1, 0, 0);
      svals.delete();
      for (int i = 0; i < 8; i++) begin
        s_cyc(0, 1, 16'(sv[t].x));
        repeat (11) s_cyc(0, 0, 0);
      end
      chk($sformatf("sat%0d_count", t), svals.size(), 2);
      if (svals.size() == 2) chk($sformatf("sat%0d_y2", t), svals[1], sv[t].e);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
